freq_tracker: RTL and testbench

Parametrised hill-climbing resonant-frequency tracker for the converter control path. It measures the peak current magnitude from the bipolar ADC stream over a fixed window after each frequency change. It then steps the drive frequency toward the peak, halving the step on every direction reversal and clamping at configured limits. It declares lock after repeated reversals at minimum step and drops lock if the peak later degrades. It sits between the ADC front end and the frequency synthesiser, and supersedes the fixed-width, fixed-window frequency optimiser.

---
 rtl/freq_tracker.sv | 235 +++++++++++++++++++++++
 tb/tb_freq_tracker.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_tracker.sv
// Hill-climbing resonant-frequency tracker.
// Measures the peak |current| from an offset-binary ADC stream over a window after each
// frequency change, steps the drive frequency toward the peak (halving the step on every
// direction reversal, clamping at F_MIN/F_MAX), locks after LOCK_REV reversals at minimum
// step, and unlocks when the window peak falls more than DROP below the best peak.
//
// Ports:
//   clk, nrst            clock, synchronous active-low reset
//   enable               run the tracker; low forces IDLE
//   adc_in, adc_valid    offset-binary ADC sample and its qualifier
//   freq_out, freq_valid commanded frequency and one-cycle update pulse
//   up_down              current search direction (1 = up)
//   locked               tracker is in lock
//   best_freq, best_peak best window peak since start/unlock and the frequency that gave it
//   peak_last            most recent completed window peak
module freq_tracker #(
  parameter int unsigned ADC_W     = 12,
  parameter int unsigned FREQ_W    = 20,
  parameter int unsigned SETTLE    = 31250,
  parameter int unsigned WINDOW    = 31250,
  parameter int unsigned F_INIT    = 40000,
  parameter int unsigned F_MIN     = 20000,
  parameter int unsigned F_MAX     = 80000,
  parameter int unsigned STEP_INIT = 64,
  parameter int unsigned STEP_MIN  = 1,
  parameter int unsigned LOCK_REV  = 4,
  parameter int unsigned DROP      = 102
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              enable,
  input  logic [ADC_W-1:0]  adc_in,
  input  logic              adc_valid,
  output logic [FREQ_W-1:0] freq_out,
  output logic              freq_valid,
  output logic              up_down,
  output logic              locked,
  output logic [FREQ_W-1:0] best_freq,
  output logic [ADC_W-2:0]  best_peak,
  output logic [ADC_W-2:0]  peak_last
);

  localparam int unsigned MagW   = ADC_W - 1;
  localparam int unsigned SumW   = FREQ_W + 1;
  localparam int unsigned CntMax = (SETTLE > WINDOW) ? SETTLE : WINDOW;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam int unsigned RevW   = $clog2(LOCK_REV + 1);

  typedef enum logic [2:0] {
    StIdle,
    StSettle,
    StMeasure,
    StDecide,
    StLkSettle,
    StLkMeasure,
    StLkDecide
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [MagW-1:0]   acc_q, acc_d;
  logic [FREQ_W-1:0] freq_q, freq_d;
  logic              fv_q, fv_d;
  logic              dir_q, dir_d;
  logic              lock_q, lock_d;
  logic [FREQ_W-1:0] bf_q, bf_d;
  logic [MagW-1:0]   bp_q, bp_d;
  logic [MagW-1:0]   pl_q, pl_d;
  logic [FREQ_W-1:0] step_q, step_d;
  logic [RevW-1:0]   rev_q, rev_d;
  // Set at start and on unlock: the next window always counts as an improvement.
  logic              first_q, first_d;

  logic [MagW-1:0]   mag;
  logic [FREQ_W-1:0] step_half, step_dec;
  logic [MagW-1:0]   drop;
  logic              dir_nx;
  logic [FREQ_W-1:0] step_nx;
  logic [RevW-1:0]   rev_nx;
  logic [SumW-1:0]   sum;

  // (2^ADC_W-1) - adc_in is the bitwise complement for the negative half.
  assign mag       = adc_in[ADC_W-1] ? ~adc_in[MagW-1:0] : adc_in[MagW-1:0];
  assign step_half = step_q >> 1;
  assign step_dec  = (step_half < FREQ_W'(STEP_MIN)) ? FREQ_W'(STEP_MIN) : step_half;
  assign drop      = (bp_q > acc_q) ? (bp_q - acc_q) : '0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    freq_d  = freq_q;
    fv_d    = 1'b0;
    dir_d   = dir_q;
    lock_d  = lock_q;
    bf_d    = bf_q;
    bp_d    = bp_q;
    pl_d    = pl_q;
    step_d  = step_q;
    rev_d   = rev_q;
    first_d = first_q;
    dir_nx  = dir_q;
    step_nx = step_q;
    rev_nx  = rev_q;
    sum     = '0;

    if (!enable) begin
      // Abort wins over everything, including a window ending this cycle.
      state_d = StIdle;
      cnt_d   = '0;
      acc_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          cnt_d   = '0;
          state_d = lock_q ? StLkSettle : StSettle;
        end

        StSettle, StLkSettle: begin
          if (cnt_q == CntW'(SETTLE - 1)) begin
            cnt_d   = '0;
            acc_d   = '0;
            state_d = (state_q == StSettle) ? StMeasure : StLkMeasure;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end

        StMeasure, StLkMeasure: begin
          if (adc_valid && (mag > acc_q)) acc_d = mag;
          if (cnt_q == CntW'(WINDOW - 1)) begin
            cnt_d   = '0;
            state_d = (state_q == StMeasure) ? StDecide : StLkDecide;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end

        StDecide: begin
          pl_d    = acc_q;
          first_d = 1'b0;
          if (first_q || (acc_q > bp_q)) begin
            bp_d = acc_q;
            bf_d = freq_q;
          end
          if (!first_q && (acc_q < pl_q)) begin
            dir_nx  = ~dir_q;
            step_nx = step_dec;
            if (step_q == FREQ_W'(STEP_MIN)) rev_nx = rev_q + RevW'(1);
          end
          step_d = step_nx;
          rev_d  = rev_nx;
          dir_d  = dir_nx;
          fv_d   = 1'b1;
          if (rev_nx == RevW'(LOCK_REV)) begin
            freq_d  = bf_d;
            lock_d  = 1'b1;
            state_d = StLkSettle;
          end else begin
            // One extra bit catches both overflow above F_MAX and borrow below zero.
            sum = dir_nx ? ({1'b0, freq_q} + {1'b0, step_nx})
                         : ({1'b0, freq_q} - {1'b0, step_nx});
            if (dir_nx && (sum > SumW'(F_MAX))) begin
              freq_d = FREQ_W'(F_MAX);
              dir_d  = ~dir_nx;
            end else if (!dir_nx && (sum[FREQ_W] || (sum < SumW'(F_MIN)))) begin
              freq_d = FREQ_W'(F_MIN);
              dir_d  = ~dir_nx;
            end else begin
              freq_d = sum[FREQ_W-1:0];
            end
            state_d = StSettle;
          end
        end

        StLkDecide: begin
          pl_d = acc_q;
          if (32'(drop) > DROP) begin
            lock_d  = 1'b0;
            step_d  = FREQ_W'(STEP_INIT);
            rev_d   = '0;
            bp_d    = '0;
            first_d = 1'b1;
            state_d = StSettle;
          end else begin
            state_d = StLkSettle;
          end
        end

        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      acc_q   <= '0;
      freq_q  <= FREQ_W'(F_INIT);
      fv_q    <= 1'b0;
      dir_q   <= 1'b1;
      lock_q  <= 1'b0;
      bf_q    <= FREQ_W'(F_INIT);
      bp_q    <= '0;
      pl_q    <= '0;
      step_q  <= FREQ_W'(STEP_INIT);
      rev_q   <= '0;
      first_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      freq_q  <= freq_d;
      fv_q    <= fv_d;
      dir_q   <= dir_d;
      lock_q  <= lock_d;
      bf_q    <= bf_d;
      bp_q    <= bp_d;
      pl_q    <= pl_d;
      step_q  <= step_d;
      rev_q   <= rev_d;
      first_q <= first_d;
    end
  end

  assign freq_out   = freq_q;
  assign freq_valid = fv_q;
  assign up_down    = dir_q;
  assign locked     = lock_q;
  assign best_freq  = bf_q;
  assign best_peak  = bp_q;
  assign peak_last  = pl_q;

endmodule

// File: tb/tb_freq_tracker.sv
// Scoreboard bench for freq_tracker with a short SETTLE/WINDOW. The stimulus process owns a
// plant model and an integer reference of the tracker rules; each window it pushes the
// expected post-decision outputs (with the cycle they must appear) into a queue, and a
// monitor compares whenever that cycle arrives or the DUT pulses freq_valid.
module tb_freq_tracker;
  localparam int S     = 4;
  localparam int W     = 8;
  localparam int FINIT = 40000;
  localparam int FMIN  = 20000;
  localparam int FMAX  = 80000;
  localparam int STEP0 = 64;
  localparam int LREV  = 4;
  localparam int DRP   = 102;
  localparam int FINIT2 = FMAX - 10;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        enable = 1'b0;
  logic        en2 = 1'b0;
  logic        adc_valid = 1'b0;
  logic [11:0] adc_in = '0;
  logic [19:0] freq_out, best_freq, freq_out2, best_freq2;
  logic        freq_valid, up_down, locked, fv2, ud2, lk2;
  logic [10:0] best_peak, peak_last, bp2, pl2;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  freq_tracker #(.SETTLE(S), .WINDOW(W)) u_dut (
    .clk(clk), .nrst(nrst), .enable(enable), .adc_in(adc_in), .adc_valid(adc_valid),
    .freq_out(freq_out), .freq_valid(freq_valid), .up_down(up_down), .locked(locked),
    .best_freq(best_freq), .best_peak(best_peak), .peak_last(peak_last)
  );

  freq_tracker #(.SETTLE(S), .WINDOW(W), .F_INIT(FINIT2)) u_clamp (
    .clk(clk), .nrst(nrst), .enable(en2), .adc_in(adc_in), .adc_valid(adc_valid),
    .freq_out(freq_out2), .freq_valid(fv2), .up_down(ud2), .locked(lk2),
    .best_freq(best_freq2), .best_peak(bp2), .peak_last(pl2)
  );

  typedef struct {
    int cyc; int pulse; int f; int dir; int lk; int pl; int bp; int bf;
  } exp_t;
  typedef struct { int f; int dir; } exp2_t;

  exp_t  q[$];
  exp2_t q2[$];
  int    n_chk = 0;
  int    n_fail = 0;
  bit    mon_en = 1'b0;

  // Reference state, plain integers.
  int mf, mdir, mstep, mrev, mlk, mbf, mbp, mpl, mfirst;
  int mode, off;
  int ex_pk[$];
  bit special;

  function automatic void chk(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  always @(negedge clk) begin : mon
    exp_t  e;
    exp2_t e2;
    if (mon_en) begin
      if (q.size() != 0 && q[0].cyc == cyc) begin
        e = q.pop_front();
        chk("freq_valid", int'(freq_valid), e.pulse);
        chk("freq_out", int'(freq_out), e.f);
        chk("up_down", int'(up_down), e.dir);
        chk("locked", int'(locked), e.lk);
        chk("peak_last", int'(peak_last), e.pl);
        chk("best_peak", int'(best_peak), e.bp);
        chk("best_freq", int'(best_freq), e.bf);
      end else begin
        chk("spurious freq_valid", int'(freq_valid), 0);
      end
      if (fv2) begin
        if (q2.size() != 0) begin
          e2 = q2.pop_front();
          chk("clamp freq_out", int'(freq_out2), e2.f);
          chk("clamp up_down", int'(ud2), e2.dir);
        end else begin
          chk("clamp spurious freq_valid", int'(fv2), 0);
        end
      end
    end
  end

  task automatic model_reset();
    mf = FINIT; mdir = 1; mstep = STEP0; mrev = 0; mlk = 0;
    mbf = FINIT; mbp = 0; mpl = 0; mfirst = 1;
  endtask

  function automatic int plant(input int f);
    int p;
    if (mode == 0) p = 2000 - ((f > 40200) ? f - 40200 : 40200 - f) - off;
    else           p = (f - 20000) / 32;
    if (p < 0) p = 0;
    if (p > 2047) p = 2047;
    return p;
  endfunction

  task automatic model_decide(input int pk, input int when);
    exp_t e;
    int prev, nxt;
    if (mlk == 0) begin
      prev = mpl;
      mpl = pk;
      if (mfirst != 0 || pk > mbp) begin mbp = pk; mbf = mf; end
      if (mfirst == 0 && pk < prev) begin
        mdir = 1 - mdir;
        if (mstep == 1) mrev++;
        mstep = (mstep / 2 < 1) ? 1 : mstep / 2;
      end
      mfirst = 0;
      if (mrev == LREV) begin
        mf = mbf; mlk = 1;
      end else begin
        nxt = (mdir != 0) ? mf + mstep : mf - mstep;
        if (nxt > FMAX)      begin nxt = FMAX; mdir = 1 - mdir; end
        else if (nxt < FMIN) begin nxt = FMIN; mdir = 1 - mdir; end
        mf = nxt;
      end
      e.pulse = 1;
    end else begin
      mpl = pk;
      if (mbp - pk > DRP) begin
        mlk = 0; mstep = STEP0; mrev = 0; mbp = 0; mfirst = 1;
      end
      e.pulse = 0;
    end
    e.cyc = when; e.f = mf; e.dir = mdir; e.lk = mlk; e.pl = mpl; e.bp = mbp; e.bf = mbf;
    q.push_back(e);
  endtask

  // Samples outside the window carry full-scale magnitude: they must never be measured.
  task automatic drive_junk();
    adc_in = ($urandom_range(1) != 0) ? 12'h7FF : 12'h800;
    adc_valid = 1'b1;
  endtask

  // Called at the negedge right after the DUT entered (LOCKED_)SETTLE.
  task automatic run_round();
    int p0, pk, pos, m;
    logic [11:0] wa [W];
    logic        wv [W];
    p0 = cyc;
    pk = (mode == 2) ? ex_pk.pop_front() : plant(mf);
    pos = $urandom_range(W - 1);
    for (int j = 0; j < W; j++) begin
      wa[j] = 12'($urandom);
      wv[j] = 1'b0;
      if (special) begin
        if (j == 0) begin wa[j] = 12'hFFF; wv[j] = 1'b1; end
        if (j == 1) begin wa[j] = 12'h7FF; wv[j] = 1'b1; end
        if (j == 2) begin wa[j] = 12'h800; wv[j] = 1'b1; end
      end else if (!(mode == 2 && pk == 0)) begin
        wv[j] = (j == pos) || ($urandom_range(1) != 0);
        if (wv[j]) begin
          m = (j == pos) ? pk : int'($urandom_range(pk));
          wa[j] = ($urandom_range(1) != 0) ? 12'(m) : 12'(4095 - m);
        end
      end
    end
    special = 1'b0;
    model_decide(pk, p0 + S + W + 1);
    for (int i = 0; i < S + W + 1; i++) begin
      if (i >= S && i < S + W) begin
        adc_in = wa[i-S]; adc_valid = wv[i-S];
      end else begin
        drive_junk();
      end
      @(negedge clk);
    end
  endtask

  // Drop enable (or assert reset) k samples into the measurement window.
  task automatic partial_round(input int k, input bit use_rst);
    for (int i = 0; i <= S + k; i++) begin
      if (i < S) drive_junk();
      else begin adc_in = 12'h7FF; adc_valid = 1'b1; end
      if (i == S + k) begin
        if (use_rst) nrst = 1'b0;
        else         enable = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic start_run(input bit both);
    enable = 1'b1;
    en2 = both;
    @(negedge clk);
  endtask

  task automatic do_reset();
    nrst = 1'b0; enable = 1'b0; en2 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst freq_out", int'(freq_out), FINIT);
    chk("rst up_down", int'(up_down), 1);
    chk("rst locked", int'(locked), 0);
    chk("rst freq_valid", int'(freq_valid), 0);
    chk("rst best_freq", int'(best_freq), FINIT);
    chk("rst best_peak", int'(best_peak), 0);
    chk("rst peak_last", int'(peak_last), 0);
    chk("rst clamp freq_out", int'(freq_out2), FINIT2);
    chk("rst clamp best_freq", int'(best_freq2), FINIT2);
    chk("rst clamp up_down", int'(ud2), 1);
    chk("rst clamp locked", int'(lk2), 0);
    chk("rst clamp best_peak", int'(bp2), 0);
    chk("rst clamp peak_last", int'(pl2), 0);
    nrst = 1'b1;
    model_reset();
  endtask

  task automatic check_hold(input string tag);
    chk({tag, " freq_out hold"}, int'(freq_out), mf);
    chk({tag, " up_down hold"}, int'(up_down), mdir);
    chk({tag, " locked hold"}, int'(locked), mlk);
    chk({tag, " peak_last hold"}, int'(peak_last), mpl);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    mode = 0; off = 0; special = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    do_reset();
    mon_en = 1'b1;
    repeat (5) @(negedge clk);

    // Magnitude folding and an all-invalid window.
    mode = 2;
    ex_pk = '{2047, 0, 500, 1200};
    special = 1'b1;
    start_run(1'b0);
    repeat (4) run_round();

    // Reset in the middle of a window.
    partial_round(3, 1'b1);
    do_reset();

    // Hill climb to lock on a tent-shaped plant.
    mode = 0; off = 0;
    start_run(1'b0);
    for (int r = 0; r < 300 && mlk == 0; r++) run_round();
    chk("lock asserted", int'(locked), 1);
    chk("lock freq within 1 of 40200",
        int'(freq_out >= 20'd40199 && freq_out <= 20'd40201), 1);

    // A drop of exactly DROP keeps lock; one more LSB breaks it.
    off = DRP;
    repeat (3) run_round();
    chk("lock kept at DROP", int'(locked), 1);
    off = DRP + 1;
    run_round();
    chk("lock lost above DROP", int'(locked), 0);
    repeat (4) run_round();

    // Enable abort mid-window, then at the window's last cycle.
    partial_round(3, 1'b0);
    check_hold("abort mid");
    repeat (3) @(negedge clk);
    start_run(1'b0);
    repeat (2) run_round();
    partial_round(W - 1, 1'b0);
    check_hold("abort end");
    repeat (2) @(negedge clk);
    start_run(1'b0);
    run_round();

    // Clamp at F_MAX on a rising plant, second instance starting at F_MAX-10.
    do_reset();
    mode = 1;
    q2.push_back('{FMAX, 0});
    q2.push_back('{FMAX - STEP0, 0});
    q2.push_back('{FMAX - 2 * STEP0, 0});
    start_run(1'b1);
    repeat (3) run_round();
    en2 = 1'b0;
    enable = 1'b0;
    repeat (5) @(negedge clk);

    chk("scoreboard drained", q.size(), 0);
    chk("clamp scoreboard drained", q2.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
